// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. Produces one
//   quotient bit per cycle and holds the result until it is accepted.
//   The last iteration and the sign fix-up share one edge, so a normal
//   operation shows out_valid after WIDTH+1 edges counted from the accept
//   edge. Divide-by-zero and signed overflow finish on the accept edge.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operands/op valid
//   in_ready   out  1      unit idle, can accept an operation
//   dividend   in   WIDTH  numerator (rs1)
//   divisor    in   WIDTH  denominator (rs2)
//   op         in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   kill       in   1      abort current operation (pipeline flush)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  quotient or remainder
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [1:0]       op,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Two's-complement negate.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    state_e             state_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   div_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               quo_neg_q;
    logic               rem_neg_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;

    // Accept-side decode
    logic               is_signed_d;
    logic               a_neg_d;
    logic               b_neg_d;
    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               div_zero_d;
    logic               overflow_d;
    logic [WIDTH-1:0]   special_d;

    // Iteration datapath
    logic [WIDTH:0]     rem_shift_d;
    logic [WIDTH:0]     diff_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   final_d;

    // Decode operands on the accept cycle: magnitudes, signs and special cases.
    always_comb begin
        is_signed_d = ~op[0];
        a_neg_d     = is_signed_d & dividend[WIDTH-1];
        b_neg_d     = is_signed_d & divisor[WIDTH-1];
        a_mag_d     = a_neg_d ? negate(dividend) : dividend;
        b_mag_d     = b_neg_d ? negate(divisor)  : divisor;
        div_zero_d  = (divisor == '0);
        overflow_d  = is_signed_d && (dividend == MIN_VAL) && (divisor == '1);
        if (div_zero_d) begin
            special_d = op[1] ? dividend : '1;
        end else begin
            // Signed overflow: quotient is the most negative value, remainder zero.
            special_d = op[1] ? '0 : MIN_VAL;
        end
    end

    // One restoring step; the W+1-bit difference's top bit is the borrow.
    always_comb begin
        rem_shift_d = {rem_q, quo_q[WIDTH-1]};
        diff_d      = rem_shift_d - {1'b0, div_q};
        if (!diff_d[WIDTH]) begin
            rem_d = diff_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_shift_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (op_q[1]) begin
            final_d = rem_neg_q ? negate(rem_d) : rem_d;
        end else begin
            final_d = quo_neg_q ? negate(quo_d) : quo_d;
        end
    end

    // Control FSM and datapath registers; rst beats kill beats normal operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (kill) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        op_q       <= op;
                        quo_neg_q  <= a_neg_d ^ b_neg_d;
                        rem_neg_q  <= a_neg_d;
                        in_ready_q <= 1'b0;
                        if (div_zero_d || overflow_d) begin
                            result_q    <= special_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            quo_q   <= a_mag_d;
                            rem_q   <= '0;
                            div_q   <= b_mag_d;
                            cnt_q   <= '0;
                            state_q <= S_BUSY;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Final iteration doubles as the sign fix-up edge.
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= final_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_BUSY;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    result_q    <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit (WIDTH=32): directed corner cases,
//   flow-control/kill/reset scenarios and randomized operations compared
//   against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [1:0]   op;
    logic         kill;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    int errors;
    int checks;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .op        (op),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics using plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] o);
        longint sa;
        longint sb;
        logic [63:0] t;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) return o[1] ? (a % b) : (a / b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t = o[1] ? (sa % sb) : (sa / sb);
        return t[31:0];
    endfunction

    function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] o);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Issue one operation, check latency, result, stability while stalled and handshake.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input logic [31:0] exp, input int hold, input string tag);
        int lat;
        logic ready_seen;
        @(negedge clk);
        check_eq({tag, "_in_ready_idle"}, in_ready, 1'b1);
        in_valid = 1'b1; dividend = a; divisor = b; op = o;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(0, 3));
        lat = 1;
        ready_seen = in_ready;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            ready_seen = ready_seen | in_ready;
        end
        check_eq({tag, "_latency"}, lat, ref_latency(a, b, o));
        check_eq({tag, "_in_ready_busy"}, ready_seen, 1'b0);
        check_eq({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, out_valid, 1'b1);
            check_eq({tag, "_hold_result"}, result, exp);
            check_eq({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_post_valid"}, out_valid, 1'b0);
        check_eq({tag, "_post_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        @(negedge clk);
        in_valid = 1'b1; dividend = a; divisor = b; op = o;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Watch for a number of cycles that out_valid never rises.
    task automatic expect_quiet(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check_eq({tag, "_no_valid"}, seen, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        errors = 0; checks = 0;
        rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; op = 2'b00;
        kill = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_in_ready", in_ready, 1'b1);
        check_eq("reset_out_valid", out_valid, 1'b0);
        check_eq("reset_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        do_op(32'd100, 32'd7, 2'b01, 32'd14, 0, "divu_100_7");
        do_op(32'd100, 32'd7, 2'b11, 32'd2, 0, "remu_100_7");
        do_op(32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD, 0, "div_m7_2");
        do_op(32'hFFFF_FFF9, 32'd2, 2'b10, 32'hFFFF_FFFF, 0, "rem_m7_2");
        do_op(32'd7, 32'hFFFF_FFFE, 2'b10, 32'd1, 0, "rem_7_m2");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'd1, 0, "div_m1_m1");
        do_op(32'd5, 32'd0, 2'b01, 32'hFFFF_FFFF, 0, "divu_5_0");
        do_op(32'd5, 32'd0, 2'b11, 32'd5, 0, "remu_5_0");
        do_op(32'hFFFF_FFFB, 32'd0, 2'b00, 32'hFFFF_FFFF, 0, "div_m5_0");
        do_op(32'hFFFF_FFFB, 32'd0, 2'b10, 32'hFFFF_FFFB, 0, "rem_m5_0");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 0, "div_ovf");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0, 0, "rem_ovf");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'h0, 0, "divu_big");
        do_op(32'd1000, 32'd3, 2'b01, 32'd333, 10, "stall10");

        // Kill on a BUSY cycle
        start_op(32'd1000, 32'd9, 2'b01);
        repeat (4) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        check_eq("kill_in_ready", in_ready, 1'b1);
        check_eq("kill_out_valid", out_valid, 1'b0);
        check_eq("kill_result", result, 32'h0);
        expect_quiet(40, "kill");
        do_op(32'd1000, 32'd9, 2'b11, 32'd1, 0, "after_kill");

        // Reset mid-BUSY
        start_op(32'd12345, 32'd17, 2'b00);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        expect_quiet(40, "rst");
        do_op(32'd12345, 32'd17, 2'b00, 32'd726, 0, "after_rst");

        // Kill in IDLE blocks the accept
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; dividend = 32'd8; divisor = 32'd0; op = 2'b01;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check_eq("idle_kill_in_ready", in_ready, 1'b1);
        expect_quiet(40, "idle_kill");

        // Randomized, back-to-back
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 200));
                2: ra = -32'($urandom_range(0, 200));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            ro = 2'($urandom_range(0, 3));
            do_op(ra, rb, ro, ref_model(ra, rb, ro), int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
